// File: rtl/approx_err_monitor.sv
// Error-statistics monitor for approximate 32-bit adders: compares each beat's
// approximate sum against the exact sum and accumulates count / max / summed error.
module approx_err_monitor #(
    parameter int CNT_W = 16,
    parameter int ACC_W = 49
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [32:0]      in_sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [32:0]      max_ed,
    output logic [ACC_W-1:0] sum_ed,
    output logic             sat
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   n_q;
    logic [CNT_W-1:0]   acc_cnt_q;

    logic               s1_vld_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [32:0]        sum_q;

    logic               s2_vld_q;
    logic [32:0]        ed_q;

    logic [CNT_W-1:0]   sample_count_q;
    logic [CNT_W-1:0]   err_count_q;
    logic [32:0]        max_ed_q;
    logic [ACC_W-1:0]   sum_ed_q;
    logic               sat_q;

    logic               accept;
    logic               start_ok;
    logic [32:0]        exact_d;
    logic [32:0]        ed_d;
    logic [ACC_W:0]     sum_wide_d;

    assign in_ready = (state_q == RUN);
    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign accept   = in_valid && in_ready;
    assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));

    // Run control: the accept counter, not the stats, decides when input closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            acc_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_ok) begin
                        n_q       <= num_samples;
                        acc_cnt_q <= '0;
                        state_q   <= (num_samples == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        acc_cnt_q <= acc_cnt_q + CNT_W'(1);
                        if (acc_cnt_q == n_q - CNT_W'(1))
                            state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!s1_vld_q && !s2_vld_q)
                        state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // S1: capture the beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
        end else begin
            s1_vld_q <= accept;
            if (accept) begin
                a_q   <= in_a;
                b_q   <= in_b;
                sum_q <= in_sum;
            end
        end
    end

    // S2: exact sum and absolute error distance.
    assign exact_d = {1'b0, a_q} + {1'b0, b_q};
    assign ed_d    = (exact_d >= sum_q) ? (exact_d - sum_q) : (sum_q - exact_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld_q <= 1'b0;
            ed_q     <= '0;
        end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q)
                ed_q <= ed_d;
        end
    end

    // S3: one extra accumulator bit catches overflow past the clamp value.
    assign sum_wide_d = {1'b0, sum_ed_q} + {{(ACC_W-32){1'b0}}, ed_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_count_q <= '0;
            err_count_q    <= '0;
            max_ed_q       <= '0;
            sum_ed_q       <= '0;
            sat_q          <= 1'b0;
        end else if (start_ok) begin
            sample_count_q <= '0;
            err_count_q    <= '0;
            max_ed_q       <= '0;
            sum_ed_q       <= '0;
            sat_q          <= 1'b0;
        end else if (s2_vld_q) begin
            sample_count_q <= sample_count_q + CNT_W'(1);
            if (ed_q != '0)
                err_count_q <= err_count_q + CNT_W'(1);
            if (ed_q > max_ed_q)
                max_ed_q <= ed_q;
            if (sum_wide_d[ACC_W]) begin
                sum_ed_q <= '1;
                sat_q    <= 1'b1;
            end else begin
                sum_ed_q <= sum_wide_d[ACC_W-1:0];
            end
        end
    end

    assign sample_count = sample_count_q;
    assign err_count    = err_count_q;
    assign max_ed       = max_ed_q;
    assign sum_ed       = sum_ed_q;
    assign sat          = sat_q;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed bench for approx_err_monitor; a second instance with ACC_W=33 shares
// the stimulus so saturation can be reached with a handful of beats.
module tb_approx_err_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_samples;
    logic        in_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [32:0] in_sum;

    logic        in_ready, busy, done, sat;
    logic [15:0] sample_count, err_count;
    logic [32:0] max_ed;
    logic [48:0] sum_ed;

    logic        y_in_ready, y_busy, y_done, y_sat;
    logic [15:0] y_sample_count, y_err_count;
    logic [32:0] y_max_ed;
    logic [32:0] y_sum_ed;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    approx_err_monitor #(.CNT_W(16), .ACC_W(49)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_sum(in_sum), .busy(busy), .done(done), .sample_count(sample_count),
        .err_count(err_count), .max_ed(max_ed), .sum_ed(sum_ed), .sat(sat)
    );

    approx_err_monitor #(.CNT_W(16), .ACC_W(33)) dut33 (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(y_in_ready), .in_a(in_a), .in_b(in_b),
        .in_sum(in_sum), .busy(y_busy), .done(y_done), .sample_count(y_sample_count),
        .err_count(y_err_count), .max_ed(y_max_ed), .sum_ed(y_sum_ed), .sat(y_sat)
    );

    task automatic do_start(input logic [15:0] n);
        @(negedge clk);
        start = 1'b1;
        num_samples = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic [32:0] s);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_sum = s;
        @(negedge clk);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({busy, done, in_ready, sat, sample_count, err_count} !== '0 || max_ed !== '0 || sum_ed !== '0) begin
            failures++;
            $display("FAIL reset_init busy=%b done=%b rdy=%b cnt=%0d", busy, done, in_ready, sample_count);
        end
        @(negedge clk);
        rst = 1'b0;
        do_start(16'd4);
        beat(32'd1, 32'd1, 33'd5);
        beat(32'd2, 32'd2, 33'd4);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sample_count !== 16'd2 || err_count !== 16'd1 || max_ed !== 33'd3) begin
            failures++;
            $display("FAIL reset_prerun cnt=%0d err=%0d max=%0h want 2 1 3", sample_count, err_count, max_ed);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, in_ready, sat, sample_count, err_count} !== '0 || max_ed !== '0 || sum_ed !== '0) begin
            failures++;
            $display("FAIL reset_async busy=%b done=%b rdy=%b cnt=%0d max=%0h", busy, done, in_ready, sample_count, max_ed);
        end
        @(negedge clk);
        rst = 1'b0;
        beat(32'd7, 32'd7, 33'd0);
        beat(32'd7, 32'd7, 33'd0);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sample_count !== '0 || busy !== 1'b0 || in_ready !== 1'b0 || sum_ed !== '0) begin
            failures++;
            $display("FAIL reset_idle cnt=%0d busy=%b rdy=%b sum=%0h want all 0", sample_count, busy, in_ready, sum_ed);
        end
    endtask

    task automatic test_back_to_back();
        do_start(16'd3);
        beat(32'd1, 32'd1, 33'd1);
        beat(32'd3, 32'd5, 33'd7);
        beat(32'h200, 32'h200, 33'h400);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready rdy=%b busy=%b want 0 1", in_ready, busy);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sample_count !== 16'd3 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_latency cnt=%0d done=%b want 3 0", sample_count, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done_timing done=%b want 1", done);
        end
        wait_done();
        checks++;
        if (done !== 1'b1 || sample_count !== 16'd3 || err_count !== 16'd2 || max_ed !== 33'd1 || sum_ed !== 49'd2 || sat !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stats done=%b cnt=%0d err=%0d max=%0h sum=%0h sat=%b want 1 3 2 1 2 0",
                     done, sample_count, err_count, max_ed, sum_ed, sat);
        end
    endtask

    task automatic test_hold_valid();
        do_start(16'd2);
        beat(32'd10, 32'd0, 33'd14);
        beat(32'd0, 32'd20, 33'd11);
        for (int i = 0; i < 4; i++) beat(32'd0, 32'd0, 33'd100);
        in_valid = 1'b0;
        wait_done();
        checks++;
        if (done !== 1'b1 || sample_count !== 16'd2 || err_count !== 16'd2 || max_ed !== 33'd9 || sum_ed !== 49'd13) begin
            failures++;
            $display("FAIL hold_stats done=%b cnt=%0d err=%0d max=%0h sum=%0h want 1 2 2 9 d",
                     done, sample_count, err_count, max_ed, sum_ed);
        end
    endtask

    task automatic test_above_exact();
        do_start(16'd1);
        beat(32'd0, 32'd0, 33'h1FFFFFFFF);
        in_valid = 1'b0;
        wait_done();
        checks++;
        if (done !== 1'b1 || err_count !== 16'd1 || max_ed !== 33'h1FFFFFFFF || sum_ed !== 49'h1FFFFFFFF || sat !== 1'b0) begin
            failures++;
            $display("FAIL above_stats done=%b err=%0d max=%0h sum=%0h sat=%b want 1 1 1ffffffff 1ffffffff 0",
                     done, err_count, max_ed, sum_ed, sat);
        end
    endtask

    task automatic test_saturate();
        do_start(16'd2);
        beat(32'd0, 32'd0, 33'h1FFFFFFFF);
        beat(32'd0, 32'd0, 33'h1FFFFFFFF);
        in_valid = 1'b0;
        wait_done();
        checks++;
        if (y_done !== 1'b1 || y_sum_ed !== 33'h1FFFFFFFF || y_sat !== 1'b1) begin
            failures++;
            $display("FAIL sat33 done=%b sum=%0h sat=%b want 1 1ffffffff 1", y_done, y_sum_ed, y_sat);
        end
        checks++;
        if (sum_ed !== 49'h3FFFFFFFE || sat !== 1'b0) begin
            failures++;
            $display("FAIL sat49 sum=%0h sat=%b want 3fffffffe 0", sum_ed, sat);
        end
        do_start(16'd1);
        checks++;
        if (y_sat !== 1'b0 || y_sum_ed !== '0) begin
            failures++;
            $display("FAIL sat_clear sat=%b sum=%0h want 0 0", y_sat, y_sum_ed);
        end
        beat(32'd5, 32'd6, 33'd11);
        in_valid = 1'b0;
        wait_done();
        checks++;
        if (y_done !== 1'b1 || y_sum_ed !== '0 || y_sat !== 1'b0 || y_sample_count !== 16'd1 || y_err_count !== '0) begin
            failures++;
            $display("FAIL sat_rerun done=%b sum=%0h sat=%b cnt=%0d err=%0d want 1 0 0 1 0",
                     y_done, y_sum_ed, y_sat, y_sample_count, y_err_count);
        end
    endtask

    task automatic test_zero_and_ignore();
        do_start(16'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || sample_count !== '0 || max_ed !== '0 || sum_ed !== '0) begin
            failures++;
            $display("FAIL zero_done done=%b busy=%b rdy=%b cnt=%0d max=%0h sum=%0h want 1 0 0 0 0 0",
                     done, busy, in_ready, sample_count, max_ed, sum_ed);
        end
        beat(32'd1, 32'd2, 33'd0);
        beat(32'd1, 32'd2, 33'd0);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sample_count !== '0 || err_count !== '0 || done !== 1'b1) begin
            failures++;
            $display("FAIL zero_noaccept cnt=%0d err=%0d done=%b want 0 0 1", sample_count, err_count, done);
        end
        do_start(16'd2);
        beat(32'd4, 32'd4, 33'd6);
        in_valid = 1'b0;
        start = 1'b1;
        num_samples = 16'd5;
        @(negedge clk);
        start = 1'b0;
        beat(32'd4, 32'd4, 33'd8);
        in_valid = 1'b0;
        wait_done();
        checks++;
        if (done !== 1'b1 || sample_count !== 16'd2 || err_count !== 16'd1 || max_ed !== 33'd2 || sum_ed !== 49'd2) begin
            failures++;
            $display("FAIL ignore_start done=%b cnt=%0d err=%0d max=%0h sum=%0h want 1 2 1 2 2",
                     done, sample_count, err_count, max_ed, sum_ed);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_samples = '0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_sum = '0;
        test_reset();
        test_back_to_back();
        test_hold_valid();
        test_above_exact();
        test_saturate();
        test_zero_and_ignore();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
